receptor_moedas: RTL and testbench

- Coin-acceptor front end directly upstream of the vending machine top. It drives that block's moeda[1:0] input.
- Takes three raw, bouncy coin-sensor lines, one per coin denomination. It synchronises and debounces them, then validates the pulse width.
- A valid coin produces exactly one single-cycle moeda code. Malformed events (overlap, too short, stuck sensor) raise a one-cycle rejection strobe instead, which drives the coin-return flap.

---
 rtl/receptor_moedas.sv | 167 ++++++++++++++++
 tb/tb_receptor_moedas.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_moedas.sv
// receptor_moedas: coin-sensor front end that synchronises, debounces and
// validates pulse width before handing a single-cycle code to the vending top.
module receptor_moedas #(
    parameter int DEB_CYCLES = 16,
    parameter int MIN_PULSE  = 200,
    parameter int MAX_PULSE  = 4000,
    parameter int LOCKOUT    = 1000,
    parameter int CW         = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sensor,
    output logic [1:0] moeda,
    output logic       moeda_valida,
    output logic       rejeitar,
    output logic       ocupado
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        MEDINDO,
        EMITIR,
        REJEITAR,
        BLOQUEIO
    } state_t;

    logic [2:0]         s1;
    logic [2:0]         s2;
    logic [2:0]         deb;
    logic [2:0][DW-1:0] dcnt;

    state_t        state;
    state_t        state_n;
    logic [2:0]    mask;
    logic [2:0]    mask_n;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_n;
    logic [CW-1:0] lcnt;
    logic [CW-1:0] lcnt_n;
    logic [1:0]    code;
    logic [1:0]    moeda_n;
    logic          valida_n;
    logic          rejeitar_n;
    logic          one_hot;
    logic          hit;
    logic          other;

    // Each level only flips after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            deb  <= '0;
            dcnt <= '0;
        end else begin
            s1 <= sensor;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb[i]  <= ~deb[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    assign one_hot = (deb != 3'b000) && ((deb & (deb - 3'd1)) == 3'b000);
    assign hit     = |(deb & mask);
    assign other   = |(deb & ~mask);
    assign ocupado = (state != IDLE);

    always_comb begin
        code = 2'b00;
        unique case (1'b1)
            mask[0]: code = 2'b01;
            mask[1]: code = 2'b10;
            mask[2]: code = 2'b11;
            default: code = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mask         <= '0;
            wcnt         <= '0;
            lcnt         <= '0;
            moeda        <= 2'b00;
            moeda_valida <= 1'b0;
            rejeitar     <= 1'b0;
        end else begin
            state        <= state_n;
            mask         <= mask_n;
            wcnt         <= wcnt_n;
            lcnt         <= lcnt_n;
            moeda        <= moeda_n;
            moeda_valida <= valida_n;
            rejeitar     <= rejeitar_n;
        end
    end

    always_comb begin
        state_n = state;
        mask_n  = mask;
        wcnt_n  = wcnt;
        lcnt_n  = lcnt;
        unique case (state)
            IDLE: begin
                if (one_hot) begin
                    state_n = MEDINDO;
                    mask_n  = deb;
                    wcnt_n  = CW'(1);
                end else if (deb != 3'b000) begin
                    state_n = REJEITAR;
                end
            end
            MEDINDO: begin
                if (other) begin
                    state_n = REJEITAR;
                end else if (hit && (wcnt == CW'(MAX_PULSE))) begin
                    state_n = REJEITAR;
                end else if (hit) begin
                    wcnt_n = wcnt + CW'(1);
                end else if (wcnt >= CW'(MIN_PULSE)) begin
                    state_n = EMITIR;
                end else begin
                    state_n = REJEITAR;
                end
            end
            EMITIR, REJEITAR: begin
                state_n = BLOQUEIO;
                lcnt_n  = '0;
            end
            BLOQUEIO: begin
                if (lcnt != CW'(LOCKOUT)) begin
                    lcnt_n = lcnt + CW'(1);
                end
                if ((lcnt == CW'(LOCKOUT)) && (deb == 3'b000)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the current state, so they land one cycle later.
    always_comb begin
        moeda_n    = 2'b00;
        valida_n   = 1'b0;
        rejeitar_n = 1'b0;
        unique case (state)
            EMITIR: begin
                moeda_n  = code;
                valida_n = 1'b1;
            end
            REJEITAR: rejeitar_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_receptor_moedas.sv
// tb_receptor_moedas: directed vectors for the coin acceptor front end
// with small parameters so every corner fits in a short run.
module tb_receptor_moedas;

    logic       clk;
    logic       reset;
    logic [2:0] sensor;
    logic [1:0] moeda;
    logic       moeda_valida;
    logic       rejeitar;
    logic       ocupado;

    receptor_moedas #(
        .DEB_CYCLES(4),
        .MIN_PULSE (8),
        .MAX_PULSE (40),
        .LOCKOUT   (8),
        .CW        (13)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor      (sensor),
        .moeda       (moeda),
        .moeda_valida(moeda_valida),
        .rejeitar    (rejeitar),
        .ocupado     (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] bits;
        int         len;
        int         exp_acc;
        int         exp_rej;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[10];

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_rej = 0;
    int n_excl = 0;
    logic [1:0] last_code = 2'b00;

    always @(negedge clk) begin
        if (moeda_valida) begin
            n_acc++;
            last_code = moeda;
        end
        if (rejeitar) n_rej++;
        if ((moeda_valida && rejeitar) || (moeda_valida != (moeda != 2'b00)))
            n_excl++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (ocupado && k < 300) begin
            tick(1);
            k++;
        end
        check({name, "_idle_timeout"}, int'(ocupado), 0);
    endtask

    task automatic settle(input string name);
        tick(12);
        wait_idle(name);
        tick(4);
    endtask

    initial begin
        int a0;
        int r0;

        vecs[0] = '{3'b001, 12, 1, 0, 2'b01};
        vecs[1] = '{3'b010, 12, 1, 0, 2'b10};
        vecs[2] = '{3'b100, 12, 1, 0, 2'b11};
        vecs[3] = '{3'b001, 3,  0, 0, 2'b00};
        vecs[4] = '{3'b001, 6,  0, 1, 2'b00};
        vecs[5] = '{3'b010, 8,  1, 0, 2'b10};
        vecs[6] = '{3'b010, 7,  0, 1, 2'b00};
        vecs[7] = '{3'b100, 40, 1, 0, 2'b11};
        vecs[8] = '{3'b100, 41, 0, 1, 2'b00};
        vecs[9] = '{3'b011, 12, 0, 1, 2'b00};

        reset  = 1'b0;
        sensor = 3'b000;
        tick(3);
        check("rst_moeda", int'(moeda), 0);
        check("rst_valida", int'(moeda_valida), 0);
        check("rst_rejeitar", int'(rejeitar), 0);
        check("rst_ocupado", int'(ocupado), 0);
        reset = 1'b1;
        tick(4);

        for (int i = 0; i < 10; i++) begin
            a0 = n_acc;
            r0 = n_rej;
            sensor = vecs[i].bits;
            tick(vecs[i].len);
            sensor = 3'b000;
            settle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_acc", i), n_acc - a0, vecs[i].exp_acc);
            check($sformatf("vec%0d_rej", i), n_rej - r0, vecs[i].exp_rej);
            if (vecs[i].exp_acc > 0)
                check($sformatf("vec%0d_code", i), int'(last_code),
                      int'(vecs[i].exp_code));
        end

        // Clean coin, exact timing of the strobe and the lockout release
        a0 = n_acc;
        sensor = 3'b010;
        tick(12);
        sensor = 3'b000;
        tick(7);
        check("clean_pre_pulse", int'(moeda_valida), 0);
        tick(1);
        check("clean_moeda", int'(moeda), 2);
        check("clean_valida", int'(moeda_valida), 1);
        check("clean_no_rej", int'(rejeitar), 0);
        tick(1);
        check("clean_one_cycle", int'(moeda_valida), 0);
        tick(7);
        check("clean_busy_end", int'(ocupado), 1);
        tick(1);
        check("clean_released", int'(ocupado), 0);
        tick(4);
        check("clean_acc", n_acc - a0, 1);

        // Short glitch, then a bouncy 20-cycle pulse on channel 2
        a0 = n_acc;
        r0 = n_rej;
        sensor = 3'b001;
        tick(3);
        sensor = 3'b000;
        tick(10);
        check("glitch_idle", int'(ocupado), 0);
        for (int i = 0; i < 4; i++) begin
            sensor = (i % 2 == 0) ? 3'b100 : 3'b000;
            tick(1);
        end
        sensor = 3'b100;
        tick(20);
        for (int i = 0; i < 4; i++) begin
            sensor = (i % 2 == 0) ? 3'b000 : 3'b100;
            tick(1);
        end
        sensor = 3'b000;
        settle("bounce");
        check("bounce_acc", n_acc - a0, 1);
        check("bounce_code", int'(last_code), 3);
        check("bounce_rej", n_rej - r0, 0);

        // Overlapping channels
        a0 = n_acc;
        r0 = n_rej;
        sensor = 3'b001;
        tick(5);
        sensor = 3'b101;
        tick(10);
        sensor = 3'b000;
        settle("overlap");
        check("overlap_acc", n_acc - a0, 0);
        check("overlap_rej", n_rej - r0, 1);

        // Stuck sensor holds the block busy until the debounced fall
        a0 = n_acc;
        r0 = n_rej;
        sensor = 3'b010;
        tick(100);
        check("stuck_busy", int'(ocupado), 1);
        sensor = 3'b000;
        tick(6);
        check("stuck_busy_fall", int'(ocupado), 1);
        tick(1);
        check("stuck_released", int'(ocupado), 0);
        tick(4);
        check("stuck_rej", n_rej - r0, 1);
        check("stuck_acc", n_acc - a0, 0);
        sensor = 3'b010;
        tick(12);
        sensor = 3'b000;
        settle("after_stuck");
        check("after_stuck_acc", n_acc - a0, 1);
        check("after_stuck_code", int'(last_code), 2);
        check("after_stuck_rej", n_rej - r0, 1);

        // Second coin arriving two cycles after EMITIR is swallowed
        a0 = n_acc;
        r0 = n_rej;
        sensor = 3'b010;
        tick(12);
        sensor = 3'b000;
        tick(9);
        sensor = 3'b001;
        tick(12);
        sensor = 3'b000;
        settle("lockout");
        check("lockout_acc", n_acc - a0, 1);
        check("lockout_code", int'(last_code), 2);
        check("lockout_rej", n_rej - r0, 0);

        // Reset in the middle of a measurement
        sensor = 3'b100;
        tick(10);
        check("mid_busy", int'(ocupado), 1);
        a0 = n_acc;
        r0 = n_rej;
        reset  = 1'b0;
        sensor = 3'b000;
        #1;
        check("mid_rst_moeda", int'(moeda), 0);
        check("mid_rst_flags", int'({moeda_valida, rejeitar}), 0);
        check("mid_rst_ocupado", int'(ocupado), 0);
        tick(3);
        reset = 1'b1;
        tick(40);
        check("post_rst_acc", n_acc - a0, 0);
        check("post_rst_rej", n_rej - r0, 0);
        check("post_rst_idle", int'(ocupado), 0);

        check("exclusive_strobes", n_excl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
